seq_dtree_eval: RTL and testbench



---
 rtl/dtree_pkg.sv | 52 +++++
 rtl/dtree_node_cmp.sv | 40 ++++
 rtl/seq_dtree_eval.sv | 166 ++++++++++++++++
 tb/tb_seq_dtree_eval.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtree_pkg.sv
// Shared definitions for the sequential decision-tree evaluator.
// Node word layout (MSB..LSB): {leaf, fidx, prec, thr, left, right}.
package dtree_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWalk,
    StDone
  } dtree_state_e;

  // clog2 that never yields a zero-width field
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned right_lsb();
    return 0;
  endfunction

  function automatic int unsigned left_lsb(input int unsigned nidx_w);
    return nidx_w;
  endfunction

  function automatic int unsigned thr_lsb(input int unsigned nidx_w);
    return 2 * nidx_w;
  endfunction

  function automatic int unsigned prec_lsb(input int unsigned nidx_w, input int unsigned feat_w);
    return thr_lsb(nidx_w) + feat_w;
  endfunction

  function automatic int unsigned fidx_lsb(input int unsigned nidx_w, input int unsigned feat_w,
                                           input int unsigned prec_w);
    return prec_lsb(nidx_w, feat_w) + prec_w;
  endfunction

  function automatic int unsigned leaf_bit(input int unsigned nidx_w, input int unsigned feat_w,
                                           input int unsigned prec_w, input int unsigned fidx_w);
    return fidx_lsb(nidx_w, feat_w, prec_w) + fidx_w;
  endfunction

  function automatic int unsigned node_w(input int unsigned nidx_w, input int unsigned feat_w,
                                         input int unsigned prec_w, input int unsigned fidx_w);
    return leaf_bit(nidx_w, feat_w, prec_w, fidx_w) + 1;
  endfunction

  // A leaf carries its class in the low bits of the left-child field
  function automatic int unsigned leaf_class(input int unsigned left, input int unsigned class_w);
    return left & ((32'd1 << class_w) - 32'd1);
  endfunction

endpackage

// File: rtl/dtree_node_cmp.sv
// Single-node evaluation: feature select, precision truncation, threshold compare.
// Purely combinational so it can be shared with the ensemble block.
module dtree_node_cmp #(
  parameter int unsigned N_FEAT = 18,
  parameter int unsigned FEAT_W = 8,
  parameter int unsigned FIDX_W = 5,
  parameter int unsigned PREC_W = 4,
  parameter int unsigned NIDX_W = 6
) (
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  input  logic [FIDX_W-1:0]        fidx,
  input  logic [PREC_W-1:0]        prec,
  input  logic [FEAT_W-1:0]        thr,
  input  logic [NIDX_W-1:0]        left,
  input  logic [NIDX_W-1:0]        right,
  output logic                     take_left,
  output logic [NIDX_W-1:0]        next_ptr
);

  logic [FEAT_W-1:0] sel;
  logic [FEAT_W-1:0] top;
  int unsigned       p_eff;

  // Feature mux; an out-of-range index selects zero and is flagged by the caller
  always_comb begin
    sel = '0;
    for (int k = 0; k < N_FEAT; k++) begin
      if (fidx == FIDX_W'(k)) sel = feat[k*FEAT_W +: FEAT_W];
    end
  end

  // Keep the top p_eff bits (zero-extended); prec=0 gives 0, which is always <= thr
  always_comb begin
    p_eff     = (32'(prec) > FEAT_W) ? FEAT_W : 32'(prec);
    top       = sel >> (FEAT_W - p_eff);
    take_left = (top <= thr);
    next_ptr  = take_left ? left : right;
  end

endmodule

// File: rtl/seq_dtree_eval.sv
// Sequential decision-tree classifier: walks one node per clock from a run-time
// loaded node table. Optional macro DTREE_DEPTH_OUT_EN adds out_depth (comparisons made).
module seq_dtree_eval
  import dtree_pkg::*;
#(
  parameter int unsigned N_FEAT    = 18,
  parameter int unsigned FEAT_W    = 8,
  parameter int unsigned N_NODES   = 64,
  parameter int unsigned MAX_DEPTH = 15,
  parameter int unsigned CLASS_W   = 2,
  localparam int unsigned FIDX_W   = clog2_min1(N_FEAT),
  localparam int unsigned NIDX_W   = clog2_min1(N_NODES),
  localparam int unsigned PREC_W   = clog2_min1(FEAT_W + 1),
  localparam int unsigned NODE_W   = node_w(NIDX_W, FEAT_W, PREC_W, FIDX_W),
  localparam int unsigned DEPTH_W  = clog2_min1(MAX_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  input  logic                     cfg_we,
  input  logic [NIDX_W-1:0]        cfg_addr,
  input  logic [NODE_W-1:0]        cfg_wdata
`ifdef DTREE_DEPTH_OUT_EN
  ,
  output logic [DEPTH_W-1:0]       out_depth
`endif
);

  localparam int unsigned RightLsb = right_lsb();
  localparam int unsigned LeftLsb  = left_lsb(NIDX_W);
  localparam int unsigned ThrLsb   = thr_lsb(NIDX_W);
  localparam int unsigned PrecLsb  = prec_lsb(NIDX_W, FEAT_W);
  localparam int unsigned FidxLsb  = fidx_lsb(NIDX_W, FEAT_W, PREC_W);
  localparam int unsigned LeafBit  = leaf_bit(NIDX_W, FEAT_W, PREC_W, FIDX_W);

  dtree_state_e              state_q, state_d;
  logic [NIDX_W-1:0]         ptr_q, ptr_d;
  logic [DEPTH_W-1:0]        depth_q, depth_d;
  logic [N_FEAT*FEAT_W-1:0]  feat_q;
  logic [CLASS_W-1:0]        class_q, class_d;
  logic                      err_q, err_d;

  logic [NODE_W-1:0]         mem [N_NODES];
  logic [NODE_W-1:0]         node;
  logic                      tbl_we;
  logic                      accept;
  logic                      take_left;
  logic [NIDX_W-1:0]         next_ptr;
  logic                      fidx_bad;
  logic                      depth_max;

  assign accept = in_valid && in_ready;
  assign tbl_we = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < N_NODES);

  // Node table write port; contents survive reset
  always_ff @(posedge clk) begin
    if (tbl_we) mem[cfg_addr] <= cfg_wdata;
  end

  // Out-of-range pointers read as an all-zero node (non-leaf, goes left to node 0)
  assign node = (32'(ptr_q) < N_NODES) ? mem[ptr_q] : '0;

  dtree_node_cmp #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .FIDX_W (FIDX_W),
    .PREC_W (PREC_W),
    .NIDX_W (NIDX_W)
  ) u_cmp (
    .feat      (feat_q),
    .fidx      (node[FidxLsb +: FIDX_W]),
    .prec      (node[PrecLsb +: PREC_W]),
    .thr       (node[ThrLsb +: FEAT_W]),
    .left      (node[LeftLsb +: NIDX_W]),
    .right     (node[RightLsb +: NIDX_W]),
    .take_left (take_left),
    .next_ptr  (next_ptr)
  );

  assign fidx_bad  = (32'(node[FidxLsb +: FIDX_W]) >= N_FEAT);
  assign depth_max = (depth_q == DEPTH_W'(MAX_DEPTH));

  // State, pointer and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
    end
  end

  // Feature latch, loaded only on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) feat_q <= '0;
    else if (accept) feat_q <= in_feat;
  end

  // Next-state and walk logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    depth_d = depth_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          ptr_d   = '0;
          depth_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (node[LeafBit]) begin
          class_d = CLASS_W'(leaf_class(32'(node[LeftLsb +: NIDX_W]), CLASS_W));
          err_d   = 1'b0;
          state_d = StDone;
        end else if (fidx_bad || depth_max) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          ptr_d   = next_ptr;
          depth_d = depth_q + DEPTH_W'(1);
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ready is held low while reset is asserted
  assign in_ready  = rst_n && (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;

`ifdef DTREE_DEPTH_OUT_EN
  logic [DEPTH_W-1:0] odepth_q;

  // Comparisons made on the path, captured when the walk ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) odepth_q <= '0;
    else if (state_q == StWalk && state_d == StDone) odepth_q <= depth_q;
  end

  assign out_depth = odepth_q;
`endif

endmodule

// File: tb/tb_seq_dtree_eval.sv
// Directed and model-checked bench for seq_dtree_eval (default parameters).
module tb_seq_dtree_eval;

  localparam int FB     = 18 * 8;
  localparam int NODE_W = 30;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [FB-1:0]     in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_class;
  logic              out_err;
  logic              cfg_we;
  logic [5:0]        cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;

  always #5 clk = ~clk;

  seq_dtree_eval #(
    .N_FEAT    (18),
    .FEAT_W    (8),
    .N_NODES   (64),
    .MAX_DEPTH (15),
    .CLASS_W   (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_feat   (in_feat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [NODE_W-1:0] tbl [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk_node(input bit leaf, input int fidx, input int prec,
                                                input int thr, input int left, input int right);
    return {leaf, 5'(fidx), 4'(prec), 8'(thr), 6'(left), 6'(right)};
  endfunction

  function automatic logic [FB-1:0] feat1(input int k, input logic [7:0] v);
    logic [FB-1:0] f;
    f = '0;
    f[k*8 +: 8] = v;
    return f;
  endfunction

  // Reference walk over the bench's copy of the table
  task automatic model(input logic [FB-1:0] f, output int cls, output int err, output int dep);
    int ptr;
    int p;
    int v;
    logic [NODE_W-1:0] w;
    ptr = 0;
    dep = 0;
    cls = 0;
    err = 1;
    for (int s = 0; s <= 16; s++) begin
      w = tbl[ptr];
      if (w[29]) begin
        cls = int'(w[11:6]) % 4;
        err = 0;
        return;
      end
      if (int'(w[28:24]) >= 18 || dep == 15) begin
        cls = 0;
        err = 1;
        return;
      end
      p = (int'(w[23:20]) > 8) ? 8 : int'(w[23:20]);
      v = (p == 0) ? 0 : int'(f[int'(w[28:24])*8 +: 8]) >> (8 - p);
      ptr = (v <= int'(w[19:12])) ? int'(w[11:6]) : int'(w[5:0]);
      dep++;
    end
  endtask

  task automatic write_node(input int addr, input logic [NODE_W-1:0] w);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = 6'(addr);
    cfg_wdata = w;
    tbl[addr] = w;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Send one vector, wait for the result; optionally complete the handshake
  task automatic run_vec(input logic [FB-1:0] f, input bit consume,
                         output int cls, output int err, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_feat  = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 32'(out_valid), 1);
    cls = int'(out_class);
    err = int'(out_err);
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    int cls, err, lat, ec, ee, ed;
    logic [FB-1:0] f;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_class", 32'(out_class), 0);
    check("rst_out_err", 32'(out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 1);

    // Single leaf at root
    write_node(0, mk_node(1, 0, 0, 0, 2, 0));
    run_vec(feat1(3, 8'h55), 1'b1, cls, err, lat);
    check("leaf_class", 32'(cls), 2);
    check("leaf_err", 32'(err), 0);
    check("leaf_lat", 32'(lat), 1);

    // Root compare on feature 7
    write_node(1, mk_node(1, 0, 0, 0, 1, 0));
    write_node(2, mk_node(1, 0, 0, 0, 3, 0));
    write_node(0, mk_node(0, 7, 2, 3, 1, 2));
    run_vec(feat1(7, 8'hC0), 1'b1, cls, err, lat);
    check("p2_class", 32'(cls), 1);
    check("p2_lat", 32'(lat), 2);
    write_node(0, mk_node(0, 7, 3, 5, 1, 2));
    run_vec(feat1(7, 8'hC0), 1'b1, cls, err, lat);
    check("p3_class", 32'(cls), 3);
    check("p3_lat", 32'(lat), 2);

    // prec=0 always goes left
    write_node(0, mk_node(0, 7, 0, 0, 1, 2));
    run_vec(feat1(7, 8'hFF), 1'b1, cls, err, lat);
    check("p0_class", 32'(cls), 1);

    // prec above FEAT_W acts as full width
    write_node(0, mk_node(0, 7, 12, 8'hC0, 1, 2));
    run_vec(feat1(7, 8'hC0), 1'b1, cls, err, lat);
    check("p12_eq_class", 32'(cls), 1);
    run_vec(feat1(7, 8'hC1), 1'b1, cls, err, lat);
    check("p12_gt_class", 32'(cls), 3);

    // Feature index out of range
    write_node(0, mk_node(0, 25, 2, 3, 1, 2));
    run_vec(feat1(7, 8'h00), 1'b1, cls, err, lat);
    check("fidx_err", 32'(err), 1);
    check("fidx_class", 32'(cls), 0);
    check("fidx_lat", 32'(lat), 1);

    // Reset mid-walk
    write_node(0, mk_node(0, 7, 3, 5, 1, 2));
    @(negedge clk);
    in_valid = 1'b1;
    in_feat  = feat1(7, 8'hC0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 0);
    check("midrst_out_err", 32'(out_err), 0);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(feat1(7, 8'hC0), 1'b1, cls, err, lat);
    check("postrst_class", 32'(cls), 3);
    check("postrst_lat", 32'(lat), 2);

    // Self-loop hits the depth limit
    write_node(0, mk_node(0, 0, 0, 0, 0, 0));
    run_vec(feat1(0, 8'h12), 1'b1, cls, err, lat);
    check("loop_err", 32'(err), 1);
    check("loop_class", 32'(cls), 0);
    check("loop_lat", 32'(lat), 16);

    // Stall in DONE; a config write there must be ignored
    write_node(0, mk_node(1, 0, 0, 0, 1, 0));
    run_vec(feat1(0, 8'h00), 1'b0, cls, err, lat);
    check("hold_class0", 32'(cls), 1);
    for (int i = 0; i < 5; i++) begin
      cfg_we    = (i == 2);
      cfg_addr  = 6'd0;
      cfg_wdata = mk_node(1, 0, 0, 0, 3, 0);
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 1);
      check("hold_class", 32'(out_class), 1);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    run_vec(feat1(0, 8'h00), 1'b1, cls, err, lat);
    check("cfg_ignored_class", 32'(cls), 1);

    // Random table, back-to-back random vectors against the model
    for (int a = 0; a < 64; a++) begin
      write_node(a, mk_node(($urandom % 3 == 0) && (a != 0), (a == 0) ? $urandom % 18 : $urandom % 20,
                            $urandom % 13, $urandom % 256, $urandom % 64, $urandom % 64));
    end
    out_ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      f = FB'({$urandom, $urandom, $urandom, $urandom, $urandom});
      model(f, ec, ee, ed);
      if (i > 0) begin
        @(negedge clk);
        check("b2b_in_ready", 32'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_feat  = f;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(negedge clk);
        lat++;
      end
      check("rnd_class", 32'(out_class), 32'(ec));
      check("rnd_err", 32'(out_err), 32'(ee));
      check("rnd_lat", 32'(lat), 32'(ed + 1));
    end
    @(negedge clk);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
